// File: rtl/ecc_input_loader.sv
// Deserializes a 768-bit vector (MSB word first) into scalar/px/py operands and
// hands them to the scalar-multiplication core. Optional range flag: LOADER_RANGE_CHECK_EN.
module ecc_input_loader #(
   parameter  int DATA_W  = 64,
   localparam int N_WORDS = 768 / DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_start,
   input  logic              i_core_ack,
   input  logic              i_core_done,
   output logic [255:0]      o_scalar,
   output logic [255:0]      o_px,
   output logic [255:0]      o_py
`ifdef LOADER_RANGE_CHECK_EN
   ,
   output logic              o_range_err
`endif
);

   localparam int CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   // Stream handshake: a word transfers on a rising edge where i_in_valid and
   // o_in_ready are both 1; o_in_ready does not depend on i_in_valid.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      START = 2'd2,
      BUSY  = 2'd3
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, next_cnt;
   logic [767:0]     sreg, sreg_next;
   logic             accept;
   logic             last_word;

`ifdef LOADER_RANGE_CHECK_EN
   function automatic logic ge_p(input logic [255:0] x);
      return x[255] | (&x[254:5] & (x[4:0] >= 5'd13));
   endfunction
`endif

   assign accept    = i_in_valid & o_in_ready;
   assign last_word = accept && (cnt == CNT_W'(N_WORDS - 1));
   assign sreg_next = {sreg[767-DATA_W:0], i_in_data};

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         IDLE, LOAD: begin
            if (last_word) begin
               next_cnt   = '0;
               next_state = START;
            end else if (accept) begin
               next_cnt   = cnt + CNT_W'(1);
               next_state = LOAD;
            end
         end
         START: if (i_core_ack) next_state = BUSY;
         BUSY:  if (i_core_done) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs are registered from next_state so reset drives them low
   // and o_start rises on the edge that takes the final word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         o_in_ready  <= 1'b0;
         o_start     <= 1'b0;
         sreg        <= '0;
         o_scalar    <= '0;
         o_px        <= '0;
         o_py        <= '0;
`ifdef LOADER_RANGE_CHECK_EN
         o_range_err <= 1'b0;
`endif
      end else begin
         state      <= next_state;
         cnt        <= next_cnt;
         o_in_ready <= (next_state == IDLE) || (next_state == LOAD);
         o_start    <= (next_state == START);
         if (accept) sreg <= sreg_next;
         if (last_word) begin
            o_scalar    <= sreg_next[767:512];
            o_px        <= sreg_next[511:256];
            o_py        <= sreg_next[255:0];
`ifdef LOADER_RANGE_CHECK_EN
            o_range_err <= ge_p(sreg_next[511:256]) | ge_p(sreg_next[255:0]);
`endif
         end
      end
   end

endmodule

// File: tb/tb_ecc_input_loader.sv
// Table-driven bench for ecc_input_loader: vectors with expected operands, plus
// hand-written reset and ack/done corner sequences. Build with LOADER_RANGE_CHECK_EN for the flag.
module tb_ecc_input_loader;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_data;
   logic          start;
   logic          core_ack;
   logic          core_done;
   logic [255:0]  scalar;
   logic [255:0]  px;
   logic [255:0]  py;
`ifdef LOADER_RANGE_CHECK_EN
   logic          range_err;
`endif

   int n_checks;
   int n_fail;
   logic [767:0] exp_q[$];

   typedef struct {
      logic [63:0]  w [12];
      int           gap_max;
      int           ack_dly;
      bit           both;
      logic [767:0] exp_vec;
      logic         exp_rerr;
   } vec_t;

   vec_t tbl [8];

   ecc_input_loader #(.DATA_W(64)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_data   (in_data),
      .o_start     (start),
      .i_core_ack  (core_ack),
      .i_core_done (core_done),
`ifdef LOADER_RANGE_CHECK_EN
      .o_range_err (range_err),
`endif
      .o_scalar    (scalar),
      .o_px        (px),
      .o_py        (py)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [767:0] model_vec(input vec_t v);
      logic [767:0] r;
      r = '0;
      for (int i = 0; i < 12; i++) r[767 - 64*i -: 64] = v.w[i];
      return r;
   endfunction

   function automatic logic model_rerr(input logic [767:0] vec);
      logic [255:0] p;
      logic [255:0] x;
      logic [255:0] y;
      p = (256'd1 << 255) - 256'd19;
      x = vec[511:256];
      y = vec[255:0];
      return (x >= p) || (y >= p);
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- drivers ----------------
   task automatic send_words(input vec_t v, input int n);
      int t;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(v.gap_max, 0)) begin
            in_valid = 1'b0;
            tick();
         end
         in_valid = 1'b1;
         in_data  = v.w[i];
         t = 0;
         while (!in_ready && t < 50) begin
            tick();
            t++;
         end
         if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: word %0d never accepted", i);
         end
         if (i == 11) check("start_before_last", {255'd0, start}, 256'd0);
         tick();
         in_valid = 1'b0;
      end
   endtask

   task automatic run_record(input vec_t v, input string tag);
      logic [767:0] e;
      exp_q.push_back(v.exp_vec);
      send_words(v, 12);
      // junk held valid while the core owns the operands
      in_valid = 1'b1;
      in_data  = rnd64();
      check({tag, "_start_rise"}, {255'd0, start}, 256'd1);
      check({tag, "_ready_low"}, {255'd0, in_ready}, 256'd0);
      e = exp_q.pop_front();
      check({tag, "_scalar"}, scalar, e[767:512]);
      check({tag, "_px"}, px, e[511:256]);
      check({tag, "_py"}, py, e[255:0]);
`ifdef LOADER_RANGE_CHECK_EN
      check({tag, "_range_err"}, {255'd0, range_err}, {255'd0, v.exp_rerr});
`endif
      for (int k = 0; k < v.ack_dly; k++) begin
         tick();
         check({tag, "_start_hold"}, {255'd0, start}, 256'd1);
         check({tag, "_ready_start"}, {255'd0, in_ready}, 256'd0);
      end
      core_ack  = 1'b1;
      core_done = v.both;
      tick();
      core_ack  = 1'b0;
      core_done = 1'b0;
      check({tag, "_start_fall"}, {255'd0, start}, 256'd0);
      repeat ($urandom_range(4, 1) + (v.both ? 3 : 0)) begin
         tick();
         check({tag, "_ready_busy"}, {255'd0, in_ready}, 256'd0);
         check({tag, "_scalar_busy"}, scalar, e[767:512]);
      end
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      in_valid  = 1'b0;
      check({tag, "_ready_after_done"}, {255'd0, in_ready}, 256'd1);
      check({tag, "_px_after_done"}, px, e[511:256]);
      check({tag, "_py_after_done"}, py, e[255:0]);
   endtask

   // ---------------- test ----------------
   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      core_ack  = 1'b0;
      core_done = 1'b0;

      tbl[0].w = '{64'h259f4329e6f4590b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                   64'h9b05688cfb97d435, 64'hd1e3a8c47b2f6e09, 64'h0f1e2d3c4b5a6978,
                   64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h510e527fade682d1,
                   64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179, 64'h7e5541eb11b0bea2};
      tbl[0].gap_max = 0; tbl[0].ack_dly = 2; tbl[0].both = 0;
      for (int r = 1; r < 8; r++) begin
         for (int i = 0; i < 12; i++) tbl[r].w[i] = rnd64();
         tbl[r].gap_max = $urandom_range(3, 0);
         tbl[r].ack_dly = $urandom_range(3, 0);
         tbl[r].both    = $urandom_range(1, 0);
      end
      tbl[1].gap_max = 3; tbl[1].both = 0;
      tbl[2].w[0] = 64'h1759edc372ae2244; tbl[2].both = 0;
      // px = p exactly
      tbl[3].w[4] = 64'h7fffffffffffffff; tbl[3].w[5] = '1; tbl[3].w[6] = '1;
      tbl[3].w[7] = 64'hffffffffffffffed;
      tbl[3].w[8] = '0; tbl[3].w[9] = '0; tbl[3].w[10] = '0; tbl[3].w[11] = 64'd1;
      // px = p - 1, py = 0; ack and done together
      tbl[4].w[4] = 64'h7fffffffffffffff; tbl[4].w[5] = '1; tbl[4].w[6] = '1;
      tbl[4].w[7] = 64'hffffffffffffffec;
      for (int i = 8; i < 12; i++) tbl[4].w[i] = '0;
      tbl[4].both = 1;
      for (int r = 0; r < 8; r++) begin
         tbl[r].exp_vec  = model_vec(tbl[r]);
         tbl[r].exp_rerr = model_rerr(tbl[r].exp_vec);
      end

      // reset state
      #12;
      check("rst_ready", {255'd0, in_ready}, 256'd0);
      check("rst_start", {255'd0, start}, 256'd0);
      check("rst_scalar", scalar, 256'd0);
      check("rst_px", px, 256'd0);
      check("rst_py", py, 256'd0);
`ifdef LOADER_RANGE_CHECK_EN
      check("rst_range_err", {255'd0, range_err}, 256'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      check("ready_after_rst", {255'd0, in_ready}, 256'd1);

      // done/ack while idle are ignored
      core_done = 1'b1;
      core_ack  = 1'b1;
      tick();
      core_done = 1'b0;
      core_ack  = 1'b0;
      check("idle_done_ignored", {255'd0, in_ready}, 256'd1);
      check("idle_no_start", {255'd0, start}, 256'd0);

      for (int r = 0; r < 8; r++) run_record(tbl[r], $sformatf("vec%0d", r));
      check("pat2_top_word", {192'd0, tbl[2].w[0]}, {192'd0, 64'h1759edc372ae2244});

      // reset in the middle of a load, then a full clean vector
      send_words(tbl[0], 5);
      #2;
      rst_n = 1'b0;
      #2;
      check("midrst_scalar", scalar, 256'd0);
      check("midrst_ready", {255'd0, in_ready}, 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_record(tbl[1], "after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ecc_input_loader.md
Name: ecc_input_loader

Overview:
- Input stage directly upstream of the scalar-multiplication core.
- Deserializes one 768-bit test vector from a narrow valid/ready stream into three 256-bit operands: scalar M, point X, point Y.
- Hands the operands to the core with a start/ack handshake and holds them stable until the core reports done.
- Back-pressures the stream while the core is busy.

Parameters:
- DATA_W, 64, stream word width; must divide 768.
- N_WORDS, 768/DATA_W, words per vector (derived, not user-set).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_in_valid  in  1  stream word valid
- o_in_ready  out  1  loader accepts a word this cycle
- i_in_data  in  DATA_W  stream word; first word is vector bits [767:768-DATA_W] (MSB first)
- o_start  out  1  operands valid, request core start
- i_core_ack  in  1  core has latched operands
- i_core_done  in  1  one-cycle pulse, core finished
- o_scalar  out  256  vector bits [767:512]
- o_px  out  256  vector bits [511:256]
- o_py  out  256  vector bits [255:0]
- o_range_err  out  1  present only with LOADER_RANGE_CHECK_EN

Behaviour:
- Reset (async assert, sync release): state=IDLE, word counter=0, o_in_ready=0, o_start=0, shift register, o_scalar, o_px and o_py = 0, o_range_err=0.
- States: IDLE -> LOAD -> START -> BUSY -> IDLE.
- IDLE:
  - o_in_ready=1.
  - The first accepted word moves the block to LOAD with count=1.
  - Accepted word (i_in_valid & o_in_ready) shifts into the 768-bit register: reg <= {reg[767-DATA_W:0], i_in_data}.
- LOAD:
  - o_in_ready=1; each accepted word increments count.
  - When word N_WORDS-1 (zero-based) is accepted, the full vector is copied to the o_scalar/o_px/o_py registers in the same edge as the shift. The block enters START next cycle with count=0.
  - Gaps (i_in_valid=0) are allowed and hold state and count.
- START:
  - o_start=1, o_in_ready=0.
  - Stays until i_core_ack=1, then goes to BUSY with o_start deasserting at that edge.
- BUSY:
  - o_in_ready=0; operand outputs remain stable.
  - i_core_done=1 returns the block to IDLE.
- Latency:
  - o_start rises exactly 1 cycle after the last word handshake.
  - From i_core_done to o_in_ready=1 is 1 cycle.
- Simultaneous i_core_ack and i_core_done in START: ack is taken and done is ignored; the core must not pulse done before ack.
- i_core_done outside BUSY: ignored.
- Reset mid-LOAD or mid-BUSY: all partial data is discarded, the block returns to IDLE, and the next word is treated as word 0.
- Operand outputs change only on the final-word load edge; never while in START or BUSY.
- Counter width: clog2(N_WORDS). No wrap: the counter clears on the final word.

Optional Feature:
- Macro LOADER_RANGE_CHECK_EN.
- Defined:
  - o_range_err is registered at the same edge as the operand load.
  - Value = (px >= p) | (py >= p), with p = 2^255-19.
  - Compare rule for x >= p: x[255] | (&x[254:5] & (x[4:0] >= 5'd13)).
  - Flag holds until the next operand load or reset.
  - The flag is informational; the handshake is unchanged.
- Undefined: the o_range_err port and comparison logic are absent; all other behaviour is identical.

Test Plan:
- Pattern 0 as 12 back-to-back words, ack 2 cycles later:
  - first word 0x259f4329e6f4590b, last word 0x7e5541eb11b0bea2.
  - o_start rises 1 cycle after word 12.
  - o_scalar = 0x259f4329…fb97d435; o_py ends …7e5541eb11b0bea2; o_px matches bits [511:256].
- Pattern 1 with random 0–3 cycle valid gaps -> operands identical to the gapless load; o_in_ready is 0 from the last word until 1 cycle after i_core_done.
- i_in_valid held high during START/BUSY:
  - no word accepted and operands unchanged.
  - After done, pattern 2 loads correctly; o_scalar top word = 0x1759edc372ae2244.
- Assert i_rst_n=0 after 5 words of pattern 0, release, then send pattern 1 in full -> outputs equal pattern 1 exactly.
- i_core_ack and i_core_done both 1 in START -> transition to BUSY; the block waits for a later done before returning to IDLE.
- With LOADER_RANGE_CHECK_EN:
  - px = 0x7fff…ffed (= p) -> o_range_err=1.
  - px = 0x7fff…ffec, py = 0 -> o_range_err=0.
  - Pattern 0 (px top bit set, [511]=1) -> o_range_err=1.
